// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates two command ports onto the single LED frame
// buffer write port, owns the draw colour, and expands clear-screen into a
// one-column-per-cycle sweep. Grants are withheld while the scanner holds.
module fb_write_scheduler #(
  parameter bit         RR_EN     = 1'b1,
  parameter int         NUM_COLS  = 16,
  parameter logic [2:0] RGB_RESET = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic [2:0] req0_rgb,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  input  logic [2:0] req1_rgb,
  input  logic       scan_hold,
  output logic       fb_bit_we,
  output logic       fb_word_we,
  output logic [3:0] fb_col,
  output logic [3:0] fb_row,
  output logic       fb_bit,
  output logic [2:0] rgb_out,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_CLR   = 2'b01;
  localparam logic [1:0] OP_COLOR = 2'b10;
  localparam logic [1:0] OP_CLS   = 2'b11;
  localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       fb_bit_we_q, fb_bit_we_d;
  logic       fb_word_we_q, fb_word_we_d;
  logic [3:0] fb_col_q, fb_col_d;
  logic [3:0] fb_row_q, fb_row_d;
  logic       fb_bit_q, fb_bit_d;
  logic [2:0] rgb_q, rgb_d;
  logic       busy_q, busy_d;

  logic       can_grant;
  logic       grant0, grant1;
  logic [1:0] sel_op;
  logic [3:0] sel_x, sel_y;
  logic [2:0] sel_rgb;

  // Grant logic: combinational in the cycle of the winning valid; port 0
  // wins a tie unless round-robin prefers port 1.
  always_comb begin
    can_grant = (state_q == IDLE) && !scan_hold && !reset;
    grant0    = can_grant && req0_valid &&
                (!req1_valid || (RR_EN == 1'b0) || !ptr_q);
    grant1    = can_grant && req1_valid && !grant0;
    sel_op    = grant1 ? req1_op  : req0_op;
    sel_x     = grant1 ? req1_x   : req0_x;
    sel_y     = grant1 ? req1_y   : req0_y;
    sel_rgb   = grant1 ? req1_rgb : req0_rgb;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state and registered-output computation for the IDLE/CLEAR machine.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fb_bit_we_d  = 1'b0;
    fb_word_we_d = 1'b0;
    fb_col_d     = fb_col_q;
    fb_row_d     = fb_row_q;
    fb_bit_d     = fb_bit_q;
    rgb_d        = rgb_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          // The pointer always moves to the port that did not just win.
          ptr_d = grant0;
          unique case (sel_op)
            OP_SET, OP_CLR: begin
              fb_bit_we_d = 1'b1;
              fb_col_d    = sel_x;
              fb_row_d    = sel_y;
              fb_bit_d    = (sel_op == OP_SET);
            end
            OP_COLOR: rgb_d = sel_rgb;
            OP_CLS: begin
              state_d      = CLEAR;
              fb_word_we_d = 1'b1;
              fb_col_d     = 4'd0;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        // fb_col doubles as the sweep counter; it wraps to 0 on exit.
        fb_col_d = fb_col_q + 4'd1;
        if (fb_col_q == LAST_COL) begin
          state_d = IDLE;
        end else begin
          fb_word_we_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State and output registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      fb_bit_we_q  <= 1'b0;
      fb_word_we_q <= 1'b0;
      fb_col_q     <= 4'd0;
      fb_row_q     <= 4'd0;
      fb_bit_q     <= 1'b0;
      rgb_q        <= RGB_RESET;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fb_bit_we_q  <= fb_bit_we_d;
      fb_word_we_q <= fb_word_we_d;
      fb_col_q     <= fb_col_d;
      fb_row_q     <= fb_row_d;
      fb_bit_q     <= fb_bit_d;
      rgb_q        <= rgb_d;
      busy_q       <= busy_d;
    end
  end

  assign fb_bit_we  = fb_bit_we_q;
  assign fb_word_we = fb_word_we_q;
  assign fb_col     = fb_col_q;
  assign fb_row     = fb_row_q;
  assign fb_bit     = fb_bit_q;
  assign rgb_out    = rgb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed steps, grant model and a queue of
// expected registered outputs for the following cycle.
module tb_fb_write_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [3:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [2:0] req0_rgb = '0, req1_rgb = '0;
  logic       scan_hold = 1'b0;
  logic       fb_bit_we, fb_word_we, fb_bit, busy;
  logic [3:0] fb_col, fb_row;
  logic [2:0] rgb_out;

  // Fixed-priority instance, used only for its ready outputs.
  logic       fp_v0 = 1'b0, fp_v1 = 1'b0;
  logic       fp_r0, fp_r1, fp_bwe, fp_wwe, fp_bit, fp_busy;
  logic [3:0] fp_col, fp_row;
  logic [2:0] fp_rgb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fb_write_scheduler #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_rgb(req0_rgb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_rgb(req1_rgb),
    .scan_hold(scan_hold),
    .fb_bit_we(fb_bit_we), .fb_word_we(fb_word_we), .fb_col(fb_col),
    .fb_row(fb_row), .fb_bit(fb_bit), .rgb_out(rgb_out), .busy(busy)
  );

  fb_write_scheduler #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_rgb(req0_rgb),
    .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_rgb(req1_rgb),
    .scan_hold(scan_hold),
    .fb_bit_we(fp_bwe), .fb_word_we(fp_wwe), .fb_col(fp_col),
    .fb_row(fp_row), .fb_bit(fp_bit), .rgb_out(fp_rgb), .busy(fp_busy)
  );

  typedef struct {
    logic       bit_we;
    logic       word_we;
    logic [3:0] col;
    logic [3:0] row;
    logic       pix;
    logic [2:0] rgb;
    logic       busy;
    bit         chk_col;
    bit         chk_row;
  } exp_t;

  exp_t exp_q[$];

  // Reference state derived from the block's described behaviour.
  bit         m_ptr = 1'b0;
  bit         m_clear = 1'b0;
  int         m_next = 0;
  logic [2:0] m_rgb = 3'b011;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set0(input logic v, input logic [1:0] op, input logic [3:0] x,
                      input logic [3:0] y, input logic [2:0] rgb);
    req0_valid = v; req0_op = op; req0_x = x; req0_y = y; req0_rgb = rgb;
  endtask

  task automatic set1(input logic v, input logic [1:0] op, input logic [3:0] x,
                      input logic [3:0] y, input logic [2:0] rgb);
    req1_valid = v; req1_op = op; req1_x = x; req1_y = y; req1_rgb = rgb;
  endtask

  // One clock: check readys against the model, queue the expected outputs for
  // the next cycle, advance the clock, then pop and compare.
  task automatic cycle(output logic a0, output logic a1);
    exp_t e;
    logic ok, g0, g1;
    logic [1:0] op;
    #1;
    ok = !reset && !m_clear && !scan_hold;
    g0 = ok && req0_valid && (!req1_valid || !m_ptr);
    g1 = ok && req1_valid && !g0;
    check("req0_ready", {7'd0, req0_ready}, {7'd0, g0});
    check("req1_ready", {7'd0, req1_ready}, {7'd0, g1});
    if (fp_v0 || fp_v1) begin
      check("fp_req0_ready", {7'd0, fp_r0}, {7'd0, fp_v0 && !scan_hold && !reset});
      check("fp_req1_ready", {7'd0, fp_r1}, {7'd0, fp_v1 && !fp_v0 && !scan_hold && !reset});
    end
    e = '{bit_we: 1'b0, word_we: 1'b0, col: 4'd0, row: 4'd0, pix: 1'b0,
          rgb: m_rgb, busy: 1'b0, chk_col: 1'b0, chk_row: 1'b0};
    if (reset) begin
      m_ptr = 1'b0; m_clear = 1'b0; m_rgb = 3'b011;
      e.rgb = 3'b011; e.chk_col = 1'b1; e.chk_row = 1'b1;
    end else if (m_clear) begin
      if (m_next < 16) begin
        e.word_we = 1'b1; e.busy = 1'b1; e.col = 4'(m_next); e.chk_col = 1'b1;
        m_next++;
      end else begin
        m_clear = 1'b0;
      end
    end else if (g0 || g1) begin
      m_ptr = g0;
      op = g1 ? req1_op : req0_op;
      if (op == 2'b00 || op == 2'b01) begin
        e.bit_we = 1'b1; e.col = g1 ? req1_x : req0_x; e.row = g1 ? req1_y : req0_y;
        e.pix = (op == 2'b00); e.chk_col = 1'b1; e.chk_row = 1'b1;
      end else if (op == 2'b10) begin
        m_rgb = g1 ? req1_rgb : req0_rgb;
        e.rgb = m_rgb;
      end else begin
        e.word_we = 1'b1; e.busy = 1'b1; e.col = 4'd0; e.chk_col = 1'b1;
        m_clear = 1'b1; m_next = 1;
      end
    end
    exp_q.push_back(e);
    a0 = g0;
    a1 = g1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("fb_bit_we", {7'd0, fb_bit_we}, {7'd0, e.bit_we});
    check("fb_word_we", {7'd0, fb_word_we}, {7'd0, e.word_we});
    check("rgb_out", {5'd0, rgb_out}, {5'd0, e.rgb});
    check("busy", {7'd0, busy}, {7'd0, e.busy});
    if (e.chk_col) check("fb_col", {4'd0, fb_col}, {4'd0, e.col});
    if (e.chk_row) begin
      check("fb_row", {4'd0, fb_row}, {4'd0, e.row});
      check("fb_bit", {7'd0, fb_bit}, {7'd0, e.pix});
    end
    $display("cyc t=%0t r0=%b r1=%b bwe=%b wwe=%b col=%0d row=%0d bit=%b rgb=%0d busy=%b",
             $time, a0, a1, fb_bit_we, fb_word_we, fb_col, fb_row, fb_bit, rgb_out, busy);
  endtask

  initial begin
    logic a0, a1;
    logic [3:0] x0, x1;
    bit done;
    int k;

    // Reset state.
    for (int i = 0; i < 3; i++) cycle(a0, a1);
    reset = 1'b0;
    cycle(a0, a1);

    // Single pixel set: strobe at T+1 only.
    set0(1'b1, 2'b00, 4'd3, 4'd5, 3'd0);
    cycle(a0, a1);
    check("px_accept", {7'd0, a0}, 8'd1);
    req0_valid = 1'b0;
    cycle(a0, a1);
    cycle(a0, a1);

    // Port 1 alone wins; pointer back to port 0.
    set1(1'b1, 2'b00, 4'd0, 4'd0, 3'd0);
    cycle(a0, a1);
    check("solo1_accept", {7'd0, a1}, 8'd1);
    req1_valid = 1'b0;

    // Both valid: round-robin alternates 0,1,0,1,0; fixed priority always port 0.
    x0 = 4'd1; x1 = 4'd8;
    set0(1'b1, 2'b00, x0, 4'd2, 3'd0);
    set1(1'b1, 2'b01, x1, 4'd9, 3'd0);
    fp_v0 = 1'b1; fp_v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(a0, a1);
      check("rr_seq", {6'd0, a1, a0}, (i % 2 == 0) ? 8'd1 : 8'd2);
      if (a0) begin x0 = x0 + 4'd1; req0_x = x0; end
      if (a1) begin x1 = x1 + 4'd1; req1_x = x1; end
    end
    fp_v0 = 1'b0; fp_v1 = 1'b0;

    // Clear screen from port 1 while port 0 waits.
    set1(1'b1, 2'b11, 4'd0, 4'd0, 3'd0);
    set0(1'b1, 2'b00, 4'd7, 4'd7, 3'd0);
    cycle(a0, a1);
    check("cls_accept", {7'd0, a1}, 8'd1);
    req1_valid = 1'b0;
    done = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      cycle(a0, a1);
      if (a0) begin done = 1'b1; req0_valid = 1'b0; end
      else k++;
    end
    check("cls_next_accept_cycle", 8'(k), 8'd16);
    cycle(a0, a1);

    // Scan hold blocks both ports; releasing it grants in the same cycle.
    set0(1'b1, 2'b00, 4'd4, 4'd4, 3'd0);
    set1(1'b1, 2'b00, 4'd6, 4'd6, 3'd0);
    scan_hold = 1'b1;
    for (int i = 0; i < 10; i++) cycle(a0, a1);
    scan_hold = 1'b0;
    cycle(a0, a1);
    check("hold_release_grant", {7'd0, a0 | a1}, 8'd1);
    if (a0) req0_valid = 1'b0;
    if (a1) req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(a0, a1);
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end

    // Colour change, then a clear-pixel at the far corner.
    set0(1'b1, 2'b10, 4'd0, 4'd0, 3'b101);
    cycle(a0, a1);
    req0_valid = 1'b0;
    cycle(a0, a1);
    check("rgb_set", {5'd0, rgb_out}, 8'h05);
    set0(1'b1, 2'b01, 4'd15, 4'd15, 3'd0);
    cycle(a0, a1);
    req0_valid = 1'b0;
    cycle(a0, a1);
    cycle(a0, a1);

    // Reset during cycle 8 of a clear sweep.
    set0(1'b1, 2'b11, 4'd0, 4'd0, 3'd0);
    cycle(a0, a1);
    req0_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle(a0, a1);
    reset = 1'b1;
    cycle(a0, a1);
    reset = 1'b0;
    set0(1'b1, 2'b00, 4'd1, 4'd2, 3'd0);
    cycle(a0, a1);
    check("post_reset_accept", {7'd0, a0}, 8'd1);
    req0_valid = 1'b0;
    cycle(a0, a1);
    cycle(a0, a1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Arbitrates and sequences all writes into the 16x16 one-bit-per-pixel LED panel frame buffer and owns the current draw colour. Two requesters share the single frame-buffer write port: port 0 carries the UART command decoder, port 1 the on-chip animation engine. The block grants one command per cycle using round-robin or fixed priority. It expands clear-screen into a 16-cycle column sweep, and holds off writes while the panel scanner requests a stable buffer.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, port 0 wins.
- NUM_COLS, 16, number of frame-buffer column words swept by clear-screen; must be 16.
- RGB_RESET, 3'b011, draw colour after reset.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req0_valid / req1_valid  in  1  command valid.
- req0_ready / req1_ready  out  1  command accepted this cycle when both valid and ready are high.
- req0_op / req1_op  in  2  00 set pixel, 01 clear pixel, 10 set colour, 11 clear screen.
- req0_x / req1_x  in  4  column index.
- req0_y / req1_y  in  4  row index.
- req0_rgb / req1_rgb  in  3  colour, used by op 10 only.
- scan_hold  in  1  high = no new grants.
- fb_bit_we  out  1  single-pixel write strobe.
- fb_word_we  out  1  whole-column write strobe; data is implicitly 16'h0000.
- fb_col  out  4  column address.
- fb_row  out  4  row address, valid with fb_bit_we.
- fb_bit  out  1  pixel value, valid with fb_bit_we.
- rgb_out  out  3  current draw colour.
- busy  out  1  high while the clear sweep is running.

## Operation
- The state machine has two states: IDLE and CLEAR.
- IDLE:
  - If scan_hold=0, at most one reqN_ready is driven high combinationally in the same cycle as the winning reqN_valid.
  - The ready output depends on valid, state, scan_hold and the arbitration pointer only.
  - reqN_ready is never high for a requester whose valid is low.
- Arbitration with RR_EN=1:
  - The 1-bit pointer names the preferred port.
  - If only one port is valid, that port wins.
  - If both are valid, the pointer port wins.
  - On every accept the pointer becomes the other port.
  - Reset value of the pointer is 0.
- Arbitration with RR_EN=0: port 0 always wins on a tie.
- Accepted op 00 or 01:
  - Next cycle: fb_bit_we=1, fb_col=x, fb_row=y, fb_bit = 1 for op 00, 0 for op 01.
  - Then back to IDLE.
- Accepted op 10:
  - Next cycle: rgb_out=rgb.
  - No frame-buffer strobe.
- Accepted op 11:
  - Enter CLEAR.
  - fb_word_we=1 with fb_col stepping 0,1,...,15, one column per cycle.
  - After the column-15 cycle, return to IDLE.
- In CLEAR:
  - Both readys are 0.
  - busy=1.
  - scan_hold is ignored, because the sweep always runs to completion.
- Requesters must hold valid and all payload stable until accepted. The block does not latch unaccepted commands.
- When scan_hold rises, no new grant is issued from that cycle on. A write accepted in the previous cycle still strobes.
- All fb_* outputs, rgb_out and busy are registered.
- Reset values: fb_bit_we=0, fb_word_we=0, fb_col=0, fb_row=0, fb_bit=0, rgb_out=RGB_RESET, busy=0, both readys 0 while reset is high, state IDLE.
- Reset during CLEAR aborts the sweep immediately. The next cycle after reset deasserts, the block is in IDLE and busy=0. Columns already cleared stay cleared; the frame buffer owner applies its own reset pattern.

## Timing
- Latency for pixel ops: accept at cycle T gives the write strobe at T+1, lasting exactly one cycle.
- Throughput: back-to-back pixel accepts are allowed every cycle, giving one strobe per cycle.
- Clear-screen accepted at T:
  - fb_word_we=1 during T+1..T+16 with fb_col=0..15.
  - busy=1 during T+1..T+16.
  - Readys are 0 during T+1..T+16.
  - The earliest next accept is at T+17.
- Set colour accepted at T: rgb_out changes at T+1.
- A pixel write accepted in the same cycle a colour changes uses no colour; the panel scanner reads rgb_out directly.
- Address width: fb_col and fb_row are 4-bit. The sweep counter wraps from 15 back to 0, and the state exits on the wrap.

## Test plan
- After reset: rgb_out=3'b011, all strobes 0, busy=0. Then req0 op 00 x=3 y=5 accepted at T gives fb_bit_we=1, col=3, row=5, bit=1 at T+1 only.
- Both ports valid continuously with pixel ops, RR_EN=1: grants alternate 0,1,0,1 starting with 0. With RR_EN=0, port 0 is granted every cycle and req1_ready stays 0.
- req1 op 11 at T while req0 is valid: fb_word_we high for 16 cycles with col 0..15, req0_ready=0 through T+16, req0 accepted at T+17.
- scan_hold=1 with both valid: no ready for 10 cycles and no strobes. Drop scan_hold: the grant is issued the same cycle.
- req0 op 10 rgb=3'b101: rgb_out=3'b101 at T+1 and no fb strobe. Op 01 x=15 y=15: fb_bit=0, col=15, row=15.
- Assert reset at cycle 8 of a clear sweep: strobes go to 0, busy=0, rgb_out returns to 3'b011, and a new op is accepted on the first cycle after reset.
